hazard_forward_unit: RTL and testbench
======================================

// Module: hazard_forward_unit
// PURPOSE
//  Parametrised hazard and forwarding controller for the 5-stage pipeline (Fetch/Decode/Execute/Memory/Writeback).
//  Replaces the tied-off ForwardA_E/ForwardB_E = 2'b00 with real M/W forwarding.
//  Adds load-use stalling with a configurable bubble count and branch flush.
//  Keeps saturating performance counters for cycles, stalls, flushes and forwards.
// PARAMETERS
//  REG_AW     5   register-address width (RS*/RD* ports)
//  LOAD_LAT   1   bubbles inserted per load-use hazard (>=1)
//  CNT_W      32  width of every performance counter
//  ZERO_HARD  1   1: register 0 is hardwired; never forwarded, never causes a stall
// PORTS
//  clk          in   1        pipeline clock
//  rst          in   1        asynchronous active-low reset
//  RS1_D        in   REG_AW   source reg 1 of the instruction in Decode
//  RS2_D        in   REG_AW   source reg 2 of the instruction in Decode
//  RS1_E        in   REG_AW   source reg 1 in Execute
//  RS2_E        in   REG_AW   source reg 2 in Execute
//  RD_E         in   REG_AW   destination reg in Execute
//  RD_M         in   REG_AW   destination reg in Memory
//  RD_W         in   REG_AW   destination reg in Writeback
//  ResultSrcE   in   1        1 = instruction in Execute is a load
//  RegWriteE    in   1        Execute writes a register
//  RegWriteM    in   1        Memory writes a register
//  RegWriteW    in   1        Writeback writes a register
//  PCSrcE       in   1        taken branch resolved in Execute
//  cnt_clr      in   1        synchronous clear of all counters
//  ForwardA_E   out  2        00 regfile, 10 ALU_ResultM, 01 ResultW
//  ForwardB_E   out  2        same encoding, operand B
//  StallF       out  1        hold PC
//  StallD       out  1        hold the F/D register
//  FlushD       out  1        clear the F/D register
//  FlushE       out  1        clear the D/E register (insert bubble)
//  cycle_cnt    out  CNT_W    cycles since reset/clear
//  stall_cnt    out  CNT_W    cycles with StallF=1
//  flush_cnt    out  CNT_W    cycles with PCSrcE=1
//  fwd_cnt      out  CNT_W    cycles with ForwardA_E!=0 or ForwardB_E!=0
// BEHAVIOUR
//  Reset (rst=0, async)
//   - FSM goes to IDLE; hold counter = 0; all counters = 0.
//   - Every hazard output is forced to 0 for as long as rst=0.
//  Forwarding (combinational, 0-cycle latency)
//   - A: 10 if RegWriteM && RD_M==RS1_E && RD_M!=0.
//   - Otherwise A: 01 if RegWriteW && RD_W==RS1_E && RD_W!=0.
//   - Otherwise A: 00. B is identical using RS2_E.
//   - M has priority over W.
//   - The !=0 qualifiers apply only when ZERO_HARD=1.
//  Load-use detect
//   - lu = ResultSrcE && RegWriteE && (RD_E==RS1_D || RD_E==RS2_D), with RD_E!=0 when ZERO_HARD.
//  FSM IDLE
//   - lu && !PCSrcE: StallF=StallD=FlushE=1 this cycle.
//     If LOAD_LAT>1: hold counter <= LOAD_LAT-1, next state HOLD.
//  FSM HOLD
//   - StallF=StallD=FlushE=1 every cycle; hold counter decrements.
//   - Return to IDLE on the cycle the counter reaches 0.
//   - Total stall per hazard = exactly LOAD_LAT cycles.
//  Branch
//   - PCSrcE=1: FlushD=FlushE=1; StallF=StallD=0.
//   - Overrides a simultaneous lu. In HOLD it aborts the hold and the FSM returns to IDLE next cycle.
//  Counters
//   - Update on posedge clk and saturate at 2^CNT_W-1 (no wrap).
//   - cnt_clr=1 loads 0 and takes priority over increment; the clear cycle itself is not counted.
//  No combinational path exists from any counter to any hazard output.
// TESTING
//  1. rst=0 with lu conditions present -> all hazard outputs 0; counters 0.
//     Release rst -> cycle_cnt = 1 after the first edge.
//  2. RegWriteM=1, RD_M=5, RS1_E=5 and RegWriteW=1, RD_W=5 -> ForwardA_E=10.
//     Drop RegWriteM -> 01. RD_M=RS1_E=0 -> 00.
//  3. LOAD_LAT=3; load RD_E=7, RS2_D=7 -> StallF/StallD/FlushE high exactly 3 cycles.
//     stall_cnt += 3, then IDLE.
//  4. Load-use and PCSrcE=1 in the same cycle -> FlushD=FlushE=1, StallF=0, FSM stays IDLE.
//     PCSrcE during HOLD -> hold aborted.
//  5. CNT_W=4, 20 idle cycles -> cycle_cnt saturates at 15.
//     cnt_clr pulse -> 0 next edge.
//  6. Assert rst mid-HOLD -> outputs drop to 0 immediately.
//     After release: IDLE, no residual stall.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
//   Hazard and forwarding controller for a 5-stage pipeline (F/D/E/M/W).
//   - Forwarding for both Execute operands, from Memory (ALU_ResultM) or Writeback (ResultW).
//   - Load-use stalling that inserts LOAD_LAT bubbles per hazard, tracked by a small FSM.
//   - Branch flush, which overrides any stall.
//   - Saturating performance counters for cycles, stalls, flushes and forwards.
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   RS1_D, RS2_D             source registers of the instruction in Decode
//   RS1_E, RS2_E, RD_E       source/destination registers in Execute
//   RD_M, RD_W               destination registers in Memory / Writeback
//   ResultSrcE               Execute instruction is a load
//   RegWriteE/M/W            stage writes a register
//   PCSrcE                   taken branch resolved in Execute
//   cnt_clr                  synchronous clear of all counters
//   ForwardA_E, ForwardB_E   00 regfile, 10 ALU_ResultM, 01 ResultW
//   StallF, StallD           hold PC / hold the F/D register
//   FlushD, FlushE           clear the F/D / D/E register
//   cycle_cnt, stall_cnt, flush_cnt, fwd_cnt   saturating performance counters
module hazard_forward_unit #(
  parameter int REG_AW    = 5,
  parameter int LOAD_LAT  = 1,
  parameter int CNT_W     = 32,
  parameter int ZERO_HARD = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] RS1_D,
  input  logic [REG_AW-1:0] RS2_D,
  input  logic [REG_AW-1:0] RS1_E,
  input  logic [REG_AW-1:0] RS2_E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [REG_AW-1:0] RD_M,
  input  logic [REG_AW-1:0] RD_W,
  input  logic              ResultSrcE,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              PCSrcE,
  input  logic              cnt_clr,
  output logic [1:0]        ForwardA_E,
  output logic [1:0]        ForwardB_E,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  fwd_cnt
);

  // The hold counter only ever holds LOAD_LAT-1 down to 0.
  localparam int HC_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [HC_W-1:0]   r_hold_cnt;
  logic [HC_W-1:0]   w_hold_nxt;
  logic              w_rdm_ok;
  logic              w_rdw_ok;
  logic              w_rde_ok;
  logic              w_lu;
  logic [1:0]        w_fwd_a;
  logic [1:0]        w_fwd_b;
  logic              w_stall;
  logic              w_flush_d;
  logic              w_flush_e;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic              m_ok,
                                         input logic              w_ok);
    if (m_ok && (RD_M == rs)) begin
      return 2'b10;
    end else if (w_ok && (RD_W == rs)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + CNT_W'(1);
    end else begin
      return v;
    end
  endfunction

  // A destination of register 0 never counts as a producer when it is hardwired.
  assign w_rdm_ok = RegWriteM && ((ZERO_HARD == 0) || (RD_M != {REG_AW{1'b0}}));
  assign w_rdw_ok = RegWriteW && ((ZERO_HARD == 0) || (RD_W != {REG_AW{1'b0}}));
  assign w_rde_ok = (ZERO_HARD == 0) || (RD_E != {REG_AW{1'b0}});

  assign w_fwd_a = fwd_sel(RS1_E, w_rdm_ok, w_rdw_ok);
  assign w_fwd_b = fwd_sel(RS2_E, w_rdm_ok, w_rdw_ok);
  assign w_lu    = ResultSrcE && RegWriteE && w_rde_ok && ((RD_E == RS1_D) || (RD_E == RS2_D));

  // FSM state register and hold counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= {HC_W{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  // Next-state logic: a taken branch always returns to IDLE and cancels any hold.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    case (r_state)
      S_IDLE: begin
        if (PCSrcE) begin
          w_state_nxt = S_IDLE;
        end else if (w_lu && (LOAD_LAT > 1)) begin
          w_state_nxt = S_HOLD;
          w_hold_nxt  = HC_W'(LOAD_LAT - 1);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          w_state_nxt = S_IDLE;
          w_hold_nxt  = {HC_W{1'b0}};
        end else if (r_hold_cnt == HC_W'(1)) begin
          // Last bubble of this hazard: the counter reaches 0 now.
          w_state_nxt = S_IDLE;
          w_hold_nxt  = {HC_W{1'b0}};
        end else begin
          w_state_nxt = S_HOLD;
          w_hold_nxt  = r_hold_cnt - HC_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_hold_nxt  = {HC_W{1'b0}};
      end
    endcase
  end

  // Output logic: branch flush wins over any load-use stall.
  always_comb begin
    w_stall   = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (PCSrcE) begin
          w_flush_d = 1'b1;
          w_flush_e = 1'b1;
        end else if (w_lu) begin
          w_stall   = 1'b1;
          w_flush_e = 1'b1;
        end else begin
          w_stall   = 1'b0;
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          w_flush_d = 1'b1;
          w_flush_e = 1'b1;
        end else begin
          w_stall   = 1'b1;
          w_flush_e = 1'b1;
        end
      end
      default: begin
        w_stall   = 1'b0;
      end
    endcase
  end

  // Hazard outputs are held low combinationally for the whole time reset is asserted.
  assign ForwardA_E = rst ? w_fwd_a : 2'b00;
  assign ForwardB_E = rst ? w_fwd_b : 2'b00;
  assign StallF     = rst & w_stall;
  assign StallD     = rst & w_stall;
  assign FlushD     = rst & w_flush_d;
  assign FlushE     = rst & w_flush_e;

  // Saturating performance counters; a clear cycle is itself not counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= {CNT_W{1'b0}};
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
      fwd_cnt   <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      cycle_cnt <= {CNT_W{1'b0}};
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
      fwd_cnt   <= {CNT_W{1'b0}};
    end else begin
      cycle_cnt <= sat_inc(cycle_cnt, 1'b1);
      stall_cnt <= sat_inc(stall_cnt, StallF);
      flush_cnt <= sat_inc(flush_cnt, PCSrcE);
      fwd_cnt   <= sat_inc(fwd_cnt, (ForwardA_E != 2'b00) || (ForwardB_E != 2'b00));
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  logic       clk;
  logic       rst;
  logic [4:0] RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
  logic       ResultSrcE, RegWriteE, RegWriteM, RegWriteW, PCSrcE, cnt_clr;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic       StallF, StallD, FlushD, FlushE;
  logic [3:0] cycle_cnt, stall_cnt, flush_cnt, fwd_cnt;

  hazard_forward_unit #(
    .REG_AW(5), .LOAD_LAT(3), .CNT_W(4), .ZERO_HARD(1)
  ) dut (
    .clk(clk), .rst(rst),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E),
    .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
    .ResultSrcE(ResultSrcE), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .cnt_clr(cnt_clr),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .fwd_cnt(fwd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       sf;
    logic       sd;
    logic       fd;
    logic       fe;
    logic       chk_cnt;
    logic [3:0] cy;
    logic [3:0] st;
    logic [3:0] fl;
    logic [3:0] fw;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // Expected response for the inputs applied in the current cycle.
  task automatic push(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                      input logic sf, input logic fd, input logic fe,
                      input logic chk, input logic [3:0] cy, input logic [3:0] st,
                      input logic [3:0] fl, input logic [3:0] fw);
    exp_t e;
    e.name = nm; e.fa = fa; e.fb = fb; e.sf = sf; e.sd = sf; e.fd = fd; e.fe = fe;
    e.chk_cnt = chk; e.cy = cy; e.st = st; e.fl = fl; e.fw = fw;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    RS1_D = 5'd0; RS2_D = 5'd0; RS1_E = 5'd0; RS2_E = 5'd0;
    RD_E = 5'd0; RD_M = 5'd0; RD_W = 5'd0;
    ResultSrcE = 1'b0; RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    PCSrcE = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    ResultSrcE = 1'b1; RegWriteE = 1'b1; RD_E = rd; RS1_D = rs1; RS2_D = rs2;
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        checks++;
        if ((ForwardA_E !== mon_e.fa) || (ForwardB_E !== mon_e.fb) ||
            (StallF !== mon_e.sf) || (StallD !== mon_e.sd) ||
            (FlushD !== mon_e.fd) || (FlushE !== mon_e.fe) ||
            (mon_e.chk_cnt && ((cycle_cnt !== mon_e.cy) || (stall_cnt !== mon_e.st) ||
                               (flush_cnt !== mon_e.fl) || (fwd_cnt !== mon_e.fw)))) begin
          errors++;
          $display("FAIL %s: got fa=%b fb=%b sf=%b sd=%b fd=%b fe=%b cyc=%0d stl=%0d fls=%0d fwd=%0d ; exp fa=%b fb=%b sf=%b sd=%b fd=%b fe=%b cnt_chk=%b cyc=%0d stl=%0d fls=%0d fwd=%0d",
                   mon_e.name, ForwardA_E, ForwardB_E, StallF, StallD, FlushD, FlushE,
                   cycle_cnt, stall_cnt, flush_cnt, fwd_cnt,
                   mon_e.fa, mon_e.fb, mon_e.sf, mon_e.sd, mon_e.fd, mon_e.fe, mon_e.chk_cnt,
                   mon_e.cy, mon_e.st, mon_e.fl, mon_e.fw);
        end
      end
    end
  end

  initial begin
    // Reset held with load-use and forwarding conditions present.
    rst = 1'b0; cnt_clr = 1'b0;
    set_idle();
    set_lu(5'd3, 5'd3, 5'd0);
    RegWriteM = 1'b1; RD_M = 5'd4; RS1_E = 5'd4;
    step();
    push("reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
    step();
    set_idle(); rst = 1'b1;
    step();
    cnt_clr = 1'b1;
    push("release", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 4'd0, 4'd0);
    step();
    cnt_clr = 1'b0;
    push("clear0", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);

    // Forwarding
    step();
    RegWriteM = 1'b1; RD_M = 5'd5; RS1_E = 5'd5; RegWriteW = 1'b1; RD_W = 5'd5;
    push("fwd_m_prio", 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 4'd0, 4'd0);
    step();
    RegWriteM = 1'b0;
    push("fwd_w", 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd0, 4'd0, 4'd1);
    step();
    RegWriteM = 1'b1; RD_M = 5'd0; RS1_E = 5'd0;
    push("fwd_zero_m", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd0, 4'd0, 4'd2);
    step();
    RD_M = 5'd9; RD_W = 5'd9; RS1_E = 5'd9; RS2_E = 5'd9;
    push("fwd_ab_m", 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 4'd0, 4'd0, 4'd2);
    step();
    RS1_E = 5'd0; RS2_E = 5'd6; RD_W = 5'd6;
    push("fwd_b_w", 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 4'd0, 4'd0, 4'd3);
    step();
    RegWriteM = 1'b0; RD_W = 5'd0; RS2_E = 5'd0;
    push("fwd_zero_w", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 4'd0, 4'd0, 4'd4);

    // Load-use: exactly 3 stall cycles
    step();
    set_idle(); cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    set_lu(5'd7, 5'd0, 5'd7);
    push("lu_1", 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
    step();
    set_idle();
    push("lu_2", 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 4'd1, 4'd0, 4'd0);
    step();
    push("lu_3", 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 4'd2, 4'd0, 4'd0);
    step();
    push("lu_done", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd3, 4'd0, 4'd0);
    step();
    set_lu(5'd0, 5'd0, 5'd0);
    push("lu_rd0", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 4'd3, 4'd0, 4'd0);
    step();
    set_lu(5'd4, 5'd4, 5'd0); ResultSrcE = 1'b0;
    push("lu_noload", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 4'd3, 4'd0, 4'd0);
    step();
    set_lu(5'd4, 5'd4, 5'd0); RegWriteE = 1'b0;
    push("lu_nowr", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 4'd3, 4'd0, 4'd0);

    // Branch vs load-use, and branch aborting a hold
    step();
    set_idle(); cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    set_lu(5'd8, 5'd8, 5'd0); PCSrcE = 1'b1;
    push("br_over_lu", 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
    step();
    set_idle();
    push("br_idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 4'd1, 4'd0);
    step();
    set_lu(5'd8, 5'd8, 5'd0);
    push("br_lu", 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 4'd0, 4'd1, 4'd0);
    step();
    set_idle();
    push("br_hold", 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 4'd1, 4'd1, 4'd0);
    step();
    PCSrcE = 1'b1;
    push("br_abort", 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 4'd4, 4'd2, 4'd1, 4'd0);
    step();
    PCSrcE = 1'b0;
    push("br_after", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 4'd2, 4'd2, 4'd0);

    // Counter saturation and clear
    step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    repeat (20) step();
    cnt_clr = 1'b1;
    push("sat15", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 4'd0, 4'd0, 4'd0);
    step();
    cnt_clr = 1'b0;
    push("clr_sat", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
    step();
    push("after_clr", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 4'd0, 4'd0);

    // Reset asserted in the middle of a hold
    step();
    set_lu(5'd7, 5'd0, 5'd7);
    push("rh_lu", 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    step();
    RegWriteM = 1'b1; RD_M = 5'd2; RS1_E = 5'd2;
    rst = 1'b0;
    push("rh_rst", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
    step();
    set_idle(); rst = 1'b1;
    push("rh_rel", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
    step();
    push("rh_idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 4'd0, 4'd0);

    repeat (3) step();
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, exp 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
